// File: rtl/sr_chain_drain_if.sv
// Output stream of the sorted-pair drain unit: one ABS/ARG beat per
// transfer, tagged with its sorted position and an end-of-frame marker.
interface sr_chain_drain_if #(
    parameter int W  = 10,
    parameter int IW = 10
);
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data0;
    logic [W-1:0]  m_data1;
    logic [IW-1:0] m_index;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data0,
        output m_data1,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data0,
        input  m_data1,
        input  m_index,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sr_chain_drain.sv
// Drain/handoff unit after the sorter: captures one frame of sorted
// ABS/ARG pairs into a block RAM, then streams them out in order over a
// valid/ready handshake. The read side is a RAM output register feeding a
// skid register and an output register, so one beat per cycle is
// sustained while m_ready stays high and nothing is lost on a stall.
module sr_chain_drain #(
    parameter int N  = 1000,
    parameter int W  = 10,
    parameter int IW = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [W-1:0]         in0,
    input  logic [W-1:0]         in1,
    input  logic                 in_en,
    input  logic                 in_final,
    sr_chain_drain_if.master     m,
    output logic                 frame_ready,
    output logic [IW-1:0]        frame_count,
    output logic                 err_overflow,
    output logic                 err_short,
    output logic                 err_busy
);
    localparam int            AW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] N_W = IW'(N);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]   frame_count_q, frame_count_d;
    logic            err_overflow_q, err_overflow_d;
    logic            err_short_q, err_short_d;
    logic            err_busy_q, err_busy_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;

    // Stage r: RAM output register (valid/index/last travel alongside it)
    logic            r_valid_q, r_valid_d;
    logic [IW-1:0]   r_index_q, r_index_d;
    logic            r_last_q, r_last_d;
    // Stage s: skid register, only filled while the output stage is stalled
    logic            s_valid_q, s_valid_d;
    logic [W-1:0]    s_data0_q, s_data0_d;
    logic [W-1:0]    s_data1_q, s_data1_d;
    logic [IW-1:0]   s_index_q, s_index_d;
    logic            s_last_q, s_last_d;
    // Stage m: output register seen by the consumer
    logic            m_valid_q, m_valid_d;
    logic [W-1:0]    m_data0_q, m_data0_d;
    logic [W-1:0]    m_data1_q, m_data1_d;
    logic [IW-1:0]   m_index_q, m_index_d;
    logic            m_last_q, m_last_d;

    logic [2*W-1:0]  mem [N];
    logic [2*W-1:0]  rd_data_q;
    logic            wr_en, rd_en, accept, pop, room;
    logic [1:0]      occ;

    assign pop = m_valid_q && m.m_ready;

    // State register and all control/datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            frame_count_q  <= '0;
            err_overflow_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_busy_q     <= 1'b0;
            rd_ptr_q       <= '0;
            r_valid_q      <= 1'b0;
            r_index_q      <= '0;
            r_last_q       <= 1'b0;
            s_valid_q      <= 1'b0;
            s_data0_q      <= '0;
            s_data1_q      <= '0;
            s_index_q      <= '0;
            s_last_q       <= 1'b0;
            m_valid_q      <= 1'b0;
            m_data0_q      <= '0;
            m_data1_q      <= '0;
            m_index_q      <= '0;
            m_last_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            frame_count_q  <= frame_count_d;
            err_overflow_q <= err_overflow_d;
            err_short_q    <= err_short_d;
            err_busy_q     <= err_busy_d;
            rd_ptr_q       <= rd_ptr_d;
            r_valid_q      <= r_valid_d;
            r_index_q      <= r_index_d;
            r_last_q       <= r_last_d;
            s_valid_q      <= s_valid_d;
            s_data0_q      <= s_data0_d;
            s_data1_q      <= s_data1_d;
            s_index_q      <= s_index_d;
            s_last_q       <= s_last_d;
            m_valid_q      <= m_valid_d;
            m_data0_q      <= m_data0_d;
            m_data1_q      <= m_data1_d;
            m_index_q      <= m_index_d;
            m_last_q       <= m_last_d;
        end
    end

    // Frame buffer: write on capture, registered read on drain (no reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {in0, in1};
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_en) state_d = in_final ? DRAIN : CAPTURE;
            CAPTURE: if (in_final) state_d = DRAIN;
            DRAIN:   if (pop && m_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        frame_ready = (state_q == IDLE);
    end

    // Capture side: write pointer, frame length latch and sticky errors
    always_comb begin
        wr_en          = 1'b0;
        accept         = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        frame_count_d  = frame_count_q;
        err_overflow_d = err_overflow_q;
        err_short_d    = err_short_q;
        err_busy_d     = err_busy_q;
        case (state_q)
            IDLE, CAPTURE: begin
                // wr_ptr is 0 in IDLE, so the first pair lands at address 0
                accept   = in_en && (wr_ptr_q < N_W);
                wr_en    = accept;
                wr_ptr_d = wr_ptr_q + IW'(accept);
                if (in_en && !accept) begin
                    err_overflow_d = 1'b1;
                end
                // A lone in_final in IDLE has no frame to close
                if (in_final && (state_q == CAPTURE || in_en)) begin
                    frame_count_d = wr_ptr_d;
                    if (wr_ptr_d < N_W) begin
                        err_short_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (in_en || in_final) begin
                    err_busy_d = 1'b1;
                end
                if (pop && m_last_q) begin
                    wr_ptr_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Drain side: issue reads only when the r/s/m stages can absorb them
    always_comb begin
        occ = {1'b0, m_valid_q} + {1'b0, s_valid_q} + {1'b0, r_valid_q};
        // At most two beats held once this cycle's pop and read settle
        room  = (occ - {1'b0, pop}) < 2'd2;
        rd_en = (state_q == DRAIN) && (rd_ptr_q < frame_count_q) && room;
        rd_ptr_d  = (state_q == DRAIN) ? rd_ptr_q + IW'(rd_en) : '0;
        r_valid_d = rd_en;
        r_index_d = rd_ptr_q;
        r_last_d  = (rd_ptr_q == frame_count_q - IW'(1));

        s_valid_d = s_valid_q;
        s_data0_d = s_data0_q;
        s_data1_d = s_data1_q;
        s_index_d = s_index_q;
        s_last_d  = s_last_q;
        m_valid_d = m_valid_q;
        m_data0_d = m_data0_q;
        m_data1_d = m_data1_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;

        if (!m_valid_q || pop) begin
            // Output stage frees up: the older skid beat goes first
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data0_d = s_data0_q;
                m_data1_d = s_data1_q;
                m_index_d = s_index_q;
                m_last_d  = s_last_q;
                s_valid_d = r_valid_q;
                s_data0_d = rd_data_q[2*W-1:W];
                s_data1_d = rd_data_q[W-1:0];
                s_index_d = r_index_q;
                s_last_d  = r_last_q;
            end else if (r_valid_q) begin
                m_valid_d = 1'b1;
                m_data0_d = rd_data_q[2*W-1:W];
                m_data1_d = rd_data_q[W-1:0];
                m_index_d = r_index_q;
                m_last_d  = r_last_q;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (r_valid_q) begin
            // Output stalled: park the RAM beat in the (empty) skid stage
            s_valid_d = 1'b1;
            s_data0_d = rd_data_q[2*W-1:W];
            s_data1_d = rd_data_q[W-1:0];
            s_index_d = r_index_q;
            s_last_d  = r_last_q;
        end
    end

    assign m.m_valid    = m_valid_q;
    assign m.m_data0    = m_data0_q;
    assign m.m_data1    = m_data1_q;
    assign m.m_index    = m_index_q;
    assign m.m_last     = m_last_q;
    assign frame_count  = frame_count_q;
    assign err_overflow = err_overflow_q;
    assign err_short    = err_short_q;
    assign err_busy     = err_busy_q;
endmodule

// File: doc/sr_chain_drain.md
# sr_chain_drain

Drain and handoff unit at the output end of the sorting unit. Captures the sorted ABS/ARG pairs presented on the chain outputs while the MLP enable is high, buffers one full frame of up to N pairs, then streams them in sorted order to the MLP front end over a valid/ready handshake. Signals when it can accept the next frame, so the system controller can gate the next sort start.

## Interface
- N, 1000: maximum pairs per frame; sets buffer depth.
- W, 10: width of each sorted value.
- IW, 10: index/count width; must satisfy 2^IW ≥ N+1.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in0  in  W  sorted ABS value from chain 0.
- in1  in  W  sorted ARG value from chain 1.
- in_en  in  1  pair on in0/in1 is valid this cycle (MLP enable).
- in_final  in  1  frame end; may coincide with the last in_en cycle or follow it.
- m_valid  out  1  output beat valid.
- m_ready  in  1  MLP front end accepts the beat.
- m_data0  out  W  ABS value of the current beat.
- m_data1  out  W  ARG value of the current beat.
- m_index  out  IW  sorted position of the current beat, from 0.
- m_last  out  1  current beat is the last of the frame.
- frame_ready  out  1  buffer empty; the next frame may be started.
- frame_count  out  IW  pairs captured in the current or last frame.
- err_overflow  out  1  sticky: more than N pairs were offered in one frame.
- err_short  out  1  sticky: a frame ended with fewer than N pairs.
- err_busy  out  1  sticky: in_en or in_final arrived during DRAIN.

## Operation
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE: frame_ready=1. in_en=1 writes the pair at address 0, sets wr_ptr=1 and moves to CAPTURE. If in_final is also high, go straight to DRAIN (1-pair frame).
- CAPTURE: each in_en cycle writes in0/in1 at wr_ptr and increments wr_ptr.
  - An in_en with wr_ptr=N drops the pair and sets err_overflow. wr_ptr saturates at N.
- in_final in CAPTURE (with or without in_en on that cycle; a write on that cycle is included) latches frame_count=wr_ptr and moves to DRAIN.
  - If frame_count < N, set err_short.
- in_final in IDLE with in_en=0: ignored; the state stays IDLE with no output.
- DRAIN: streams buffer entries 0..frame_count-1.
  - A beat transfers when m_valid && m_ready.
  - m_last=1 when m_index=frame_count-1.
  - When the last beat transfers, go to IDLE and reset wr_ptr to 0.
- In DRAIN, in_en and in_final are ignored (no write) and set err_busy.
- Output registers hold stable while m_valid && !m_ready. m_valid never drops without a transfer.
- Buffer: single-port-per-side RAM, N×2W, registered read with one cycle latency. A prefetch/skid stage sustains one beat per cycle under continuous m_ready.
- Error flags clear only on reset.
- Reset values: state IDLE, wr_ptr 0, frame_count 0, m_valid 0, m_last 0, m_index 0, m_data0/1 0, frame_ready 1, all err flags 0. Buffer contents are don't-care.
- Reset mid-frame or mid-drain: the frame is abandoned and no further beats are issued.

## Timing
- Write: the pair sampled on the in_en edge is in RAM the next cycle.
- frame_ready falls the cycle after the first in_en and rises the cycle after the last beat transfers.
- In-to-out latency: in_final sampled at edge t gives DRAIN from t+1, first m_valid=1 at t+2 with m_index=0.
- Throughput: one beat per cycle while m_ready=1. N pairs drain in N cycles after first valid.
- Back-to-back frames: the next in_en is accepted from the cycle frame_ready reads 1.

## Test plan
- N=8 frame, in_en for 8 cycles with values (k, 100+k), in_final on the 8th -> m_valid at t+2; beats index 0..7 with data (k, 100+k); m_last on index 7; no error flags; frame_ready returns 1.
- Same frame with m_ready toggled 1,0,0,1 pattern -> beats in order, none lost or duplicated, data stable while stalled.
- 5 pairs then in_final one cycle after the last in_en -> frame_count=5, 5 beats, m_last at index 4, err_short=1.
- 10 pairs offered with N=8 -> first 8 stored and drained, err_overflow=1, frame_count=8.
- in_en pulses during DRAIN -> drained data unchanged, err_busy=1, no new frame begins.
- Reset asserted mid-drain at beat 3 -> next cycle m_valid=0, frame_ready=1, flags 0; a new 4-pair frame then drains correctly.
